// File: rtl/clock_set_ctrl_pkg.sv
// Shared types for the clock time-set controller: state encoding, field moduli, time width.
// Pure declarations; no latency and no flow control.
package clock_set_ctrl_pkg;

  localparam int TIME_W   = 7;
  localparam int MOD_MS   = 60;
  localparam int MOD_HOUR = 24;

  typedef logic [TIME_W-1:0] time_t;

  typedef enum logic [2:0] {
    ST_RUN      = 3'd0,
    ST_SET_HOUR = 3'd1,
    ST_SET_MIN  = 3'd2,
    ST_SET_SEC  = 3'd3,
    ST_COMMIT   = 3'd4
  } state_t;

  // Increment with wrap; any value at or above modulus-1 lands on 0.
  function automatic time_t inc_wrap(input time_t val, input time_t modulus);
    logic [TIME_W:0] nxt;
    nxt = {1'b0, val} + {{TIME_W{1'b0}}, 1'b1};
    if (nxt >= {1'b0, modulus}) inc_wrap = '0;
    else                        inc_wrap = nxt[TIME_W-1:0];
  endfunction

endpackage

// File: rtl/clock_set_ctrl_key.sv
// Key conditioner: 2-FF sync, stable-level debounce, one-cycle press pulse on the debounced rise.
// Latency 2 + DEBOUNCE_CYCLES cycles from key to pulse; no backpressure (pulse is fire-and-forget).
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_in_50M,
  input  logic rst,
  input  logic key_raw,
  output logic press
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q, sync_d;
  logic             level_q, level_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             press_q, press_d;

  always_comb begin
    sync_d  = {sync_q[0], key_raw};
    level_d = level_q;
    cnt_d   = cnt_q;
    // Any sample agreeing with the current level restarts the run length.
    if (sync_q[1] == level_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      level_d = sync_q[1];
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    press_d = level_d & ~level_q;
  end

  always_ff @(posedge clk_in_50M or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      level_q <= 1'b0;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press = press_q;

endmodule

// File: rtl/clock_set_ctrl.sv
// Time-set FSM for the HH:MM:SS counters: shadows, commit load strobes, per-field blink.
// Reacts one cycle after a debounced press; no backpressure, counters take load/en as levels.
module clock_set_ctrl
  import clock_set_ctrl_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int BLINK_HALF      = 12_500_000,
  parameter int COMMIT_CYCLES   = 4,
  parameter int HOUR_MOD        = MOD_HOUR
) (
  input  logic              clk_in_50M,
  input  logic              rst,
  input  logic              key_mode,
  input  logic              key_inc,
  input  logic [TIME_W-1:0] hourState,
  input  logic [TIME_W-1:0] minState,
  input  logic [TIME_W-1:0] secState,
  output logic              en_hour,
  output logic              en_min,
  output logic              en_sec,
  output logic              load_hour,
  output logic              load_min,
  output logic              load_sec,
  output logic              rst_hour,
  output logic              rst_min,
  output logic              rst_sec,
  output logic [TIME_W-1:0] data_hour,
  output logic [TIME_W-1:0] data_min,
  output logic [TIME_W-1:0] data_sec,
  output logic              blink_hour,
  output logic              blink_min,
  output logic              blink_sec,
  output logic              setting
);

  localparam int CC_W = $clog2(COMMIT_CYCLES + 1);
  localparam int BL_W = $clog2(BLINK_HALF + 1);

  logic mode_press, inc_raw_press, inc_press;

  state_t            state_q, state_d;
  time_t             hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic [CC_W-1:0]   commit_cnt_q, commit_cnt_d;
  logic [BL_W-1:0]   blink_cnt_q, blink_cnt_d;
  logic              phase_q, phase_d;
  logic              clr_q, clr_d;
  logic              enter_set;

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
    .clk_in_50M (clk_in_50M),
    .rst        (rst),
    .key_raw    (key_mode),
    .press      (mode_press)
  );

  key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
    .clk_in_50M (clk_in_50M),
    .rst        (rst),
    .key_raw    (key_inc),
    .press      (inc_raw_press)
  );

  assign inc_press = inc_raw_press & ~mode_press;

  always_comb begin
    state_d      = state_q;
    hour_d       = hour_q;
    min_d        = min_q;
    sec_d        = sec_q;
    commit_cnt_d = commit_cnt_q;
    clr_d        = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mode_press) begin
          state_d = ST_SET_HOUR;
          hour_d  = hourState;
          min_d   = minState;
          sec_d   = secState;
        end
      end
      ST_SET_HOUR: begin
        if (mode_press)     state_d = ST_SET_MIN;
        else if (inc_press) hour_d  = inc_wrap(hour_q, time_t'(HOUR_MOD));
      end
      ST_SET_MIN: begin
        if (mode_press)     state_d = ST_SET_SEC;
        else if (inc_press) min_d   = inc_wrap(min_q, time_t'(MOD_MS));
      end
      ST_SET_SEC: begin
        if (mode_press) begin
          state_d      = ST_COMMIT;
          commit_cnt_d = '0;
        end else if (inc_press) begin
          sec_d = inc_wrap(sec_q, time_t'(MOD_MS));
        end
      end
      ST_COMMIT: begin
        if (commit_cnt_q == CC_W'(COMMIT_CYCLES - 1)) state_d = ST_RUN;
        else commit_cnt_d = commit_cnt_q + CC_W'(1);
      end
      default: state_d = ST_RUN;
    endcase

    // Restarting the divider on entry keeps the new field visible first.
    enter_set = (state_d != state_q) &&
                ((state_d == ST_SET_HOUR) || (state_d == ST_SET_MIN) || (state_d == ST_SET_SEC));
    blink_cnt_d = blink_cnt_q + BL_W'(1);
    phase_d     = phase_q;
    if (enter_set) begin
      blink_cnt_d = '0;
      phase_d     = 1'b0;
    end else if (blink_cnt_q == BL_W'(BLINK_HALF - 1)) begin
      blink_cnt_d = '0;
      phase_d     = ~phase_q;
    end
  end

  always_ff @(posedge clk_in_50M or posedge rst) begin
    if (rst) begin
      state_q      <= ST_RUN;
      hour_q       <= '0;
      min_q        <= '0;
      sec_q        <= '0;
      commit_cnt_q <= '0;
      blink_cnt_q  <= '0;
      phase_q      <= 1'b0;
      clr_q        <= 1'b1;
    end else begin
      state_q      <= state_d;
      hour_q       <= hour_d;
      min_q        <= min_d;
      sec_q        <= sec_d;
      commit_cnt_q <= commit_cnt_d;
      blink_cnt_q  <= blink_cnt_d;
      phase_q      <= phase_d;
      clr_q        <= clr_d;
    end
  end

  assign en_hour    = (state_q == ST_RUN);
  assign en_min     = (state_q == ST_RUN);
  assign en_sec     = (state_q == ST_RUN);
  assign load_hour  = (state_q == ST_COMMIT);
  assign load_min   = (state_q == ST_COMMIT);
  assign load_sec   = (state_q == ST_COMMIT);
  assign rst_hour   = clr_q;
  assign rst_min    = clr_q;
  assign rst_sec    = clr_q;
  assign data_hour  = hour_q;
  assign data_min   = min_q;
  assign data_sec   = sec_q;
  assign blink_hour = phase_q & (state_q == ST_SET_HOUR);
  assign blink_min  = phase_q & (state_q == ST_SET_MIN);
  assign blink_sec  = phase_q & (state_q == ST_SET_SEC);
  assign setting    = (state_q != ST_RUN);

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with short debounce/blink/commit parameters.
module tb_clock_set_ctrl;

  logic       clk_in_50M = 1'b0;
  logic       rst = 1'b1;
  logic       key_mode = 1'b0, key_inc = 1'b0;
  logic [6:0] hourState = 7'd12, minState = 7'd34, secState = 7'd56;
  logic       en_hour, en_min, en_sec, load_hour, load_min, load_sec;
  logic       rst_hour, rst_min, rst_sec;
  logic [6:0] data_hour, data_min, data_sec;
  logic       blink_hour, blink_min, blink_sec, setting;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk_in_50M = ~clk_in_50M;

  clock_set_ctrl #(
    .DEBOUNCE_CYCLES(4), .BLINK_HALF(8), .COMMIT_CYCLES(4), .HOUR_MOD(24)
  ) dut (
    .clk_in_50M(clk_in_50M), .rst(rst), .key_mode(key_mode), .key_inc(key_inc),
    .hourState(hourState), .minState(minState), .secState(secState),
    .en_hour(en_hour), .en_min(en_min), .en_sec(en_sec),
    .load_hour(load_hour), .load_min(load_min), .load_sec(load_sec),
    .rst_hour(rst_hour), .rst_min(rst_min), .rst_sec(rst_sec),
    .data_hour(data_hour), .data_min(data_min), .data_sec(data_sec),
    .blink_hour(blink_hour), .blink_min(blink_min), .blink_sec(blink_sec),
    .setting(setting)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic m, input logic i);
    key_mode = m;
    key_inc  = i;
    repeat (12) @(negedge clk_in_50M);
    key_mode = 1'b0;
    key_inc  = 1'b0;
    repeat (12) @(negedge clk_in_50M);
  endtask

  task automatic chk_data(input string tag, input int h, input int m, input int s);
    chk({tag, "_hour"}, 32'(data_hour), 32'(h));
    chk({tag, "_min"},  32'(data_min),  32'(m));
    chk({tag, "_sec"},  32'(data_sec),  32'(s));
  endtask

  initial begin
    int  cnt;
    int  r;
    int  ones;
    logic early;
    logic bad_side;
    logic bm [0:55];
    logic bh [0:55];

    // 1 Reset
    @(negedge clk_in_50M);
    chk("rst_clr", {29'd0, rst_hour, rst_min, rst_sec}, 32'd7);
    chk("rst_en", {29'd0, en_hour, en_min, en_sec}, 32'd7);
    chk("rst_load", {29'd0, load_hour, load_min, load_sec}, 32'd0);
    chk("rst_blink", {29'd0, blink_hour, blink_min, blink_sec}, 32'd0);
    chk("rst_setting", 32'(setting), 32'd0);
    chk_data("rst_data", 0, 0, 0);
    rst = 1'b0;
    @(negedge clk_in_50M);
    chk("clr_release", {29'd0, rst_hour, rst_min, rst_sec}, 32'd0);
    chk("run_en", {29'd0, en_hour, en_min, en_sec}, 32'd7);

    // 2 Bounce: 2-cycle toggles never qualify, the steady high gives one press
    early = 1'b0;
    for (int i = 0; i < 10; i++) begin
      key_mode = ~key_mode;
      repeat (2) begin
        @(negedge clk_in_50M);
        early |= setting;
      end
    end
    chk("bounce_no_early", 32'(early), 32'd0);
    press(1'b1, 1'b0);
    chk("bounce_setting", 32'(setting), 32'd1);
    chk("bounce_en", {29'd0, en_hour, en_min, en_sec}, 32'd0);
    chk_data("capture", 12, 34, 56);

    // 3 Full set; first inc proves the single press left us in SET_HOUR
    press(1'b0, 1'b1);
    chk_data("hour_inc1", 13, 34, 56);
    repeat (12) press(1'b0, 1'b1);
    chk_data("hour_wrap25", 1, 34, 56);
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk_data("min_inc", 1, 35, 56);
    press(1'b1, 1'b0);
    repeat (4) press(1'b0, 1'b1);
    chk_data("sec_wrap", 1, 35, 0);

    key_mode = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_in_50M);
      if (load_hour) begin
        cnt++;
        chk("commit_loads", {29'd0, load_hour, load_min, load_sec}, 32'd7);
        chk("commit_en", {29'd0, en_hour, en_min, en_sec}, 32'd0);
        chk_data("commit_data", 1, 35, 0);
      end
    end
    key_mode = 1'b0;
    repeat (12) @(negedge clk_in_50M);
    chk("commit_len", 32'(cnt), 32'd4);
    chk("post_commit_en", {29'd0, en_hour, en_min, en_sec}, 32'd7);
    chk("post_commit_load", {29'd0, load_hour, load_min, load_sec}, 32'd0);
    chk("post_commit_setting", 32'(setting), 32'd0);

    // inc in RUN is ignored
    press(1'b0, 1'b1);
    chk_data("run_inc_ignored", 1, 35, 0);
    chk("run_inc_setting", 32'(setting), 32'd0);

    // 4 Wrap of hour 23 -> 0 without carry
    hourState = 7'd23; minState = 7'd7; secState = 7'd59;
    press(1'b1, 1'b0);
    chk_data("cap23", 23, 7, 59);
    press(1'b0, 1'b1);
    chk_data("hour23_wrap", 0, 7, 59);

    // 5 Blink in SET_MIN
    key_mode = 1'b1;
    for (int i = 0; i < 56; i++) begin
      @(negedge clk_in_50M);
      bm[i] = blink_min;
      bh[i] = blink_hour;
      if (i == 30) key_mode = 1'b0;
    end
    r = -1;
    for (int i = 0; i < 56; i++) if (r < 0 && bm[i]) r = i;
    chk("blink_first_rise_ok", 32'((r >= 10) && (r <= 24)), 32'd1);
    if (r < 10 || r > 24) r = 24;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(bm[r + i]);
    chk("blink_high1", 32'(ones), 32'd8);
    ones = 0;
    for (int i = 8; i < 16; i++) ones += int'(bm[r + i]);
    chk("blink_low", 32'(ones), 32'd0);
    ones = 0;
    for (int i = 16; i < 24; i++) ones += int'(bm[r + i]);
    chk("blink_high2", 32'(ones), 32'd8);
    bad_side = 1'b0;
    for (int i = 0; i < 56; i++) if (i >= r - 8) bad_side |= bh[i];
    chk("blink_hour_off", 32'(bad_side), 32'd0);
    chk("blink_sec_off", 32'(blink_sec), 32'd0);

    // SET_SEC wrap 59 -> 0 without carry into minutes
    press(1'b1, 1'b0);
    press(1'b0, 1'b1);
    chk_data("sec59_wrap", 0, 7, 0);

    // 6 Abort during COMMIT cycle 2
    key_mode = 1'b1;
    cnt = 0;
    for (int i = 0; i < 30 && cnt < 2; i++) begin
      @(negedge clk_in_50M);
      if (load_hour) cnt++;
    end
    chk("abort_reached", 32'(cnt), 32'd2);
    rst = 1'b1;
    key_mode = 1'b0;
    #1;
    chk("abort_load", {29'd0, load_hour, load_min, load_sec}, 32'd0);
    chk("abort_setting", 32'(setting), 32'd0);
    chk("abort_clr", {29'd0, rst_hour, rst_min, rst_sec}, 32'd7);
    chk_data("abort_data", 0, 0, 0);
    @(negedge clk_in_50M);
    rst = 1'b0;
    @(negedge clk_in_50M);
    chk("abort_clr_release", {29'd0, rst_hour, rst_min, rst_sec}, 32'd0);

    // Out-of-range capture and simultaneous mode+inc
    hourState = 7'd30; minState = 7'd5; secState = 7'd7;
    press(1'b1, 1'b0);
    chk_data("cap30", 30, 5, 7);
    press(1'b0, 1'b1);
    chk_data("hour30_to0", 0, 5, 7);
    press(1'b1, 1'b1);
    chk_data("mode_wins", 0, 5, 7);
    press(1'b0, 1'b1);
    chk_data("now_set_min", 0, 6, 7);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
